// File: rtl/tessia_trace_pkg.sv
// Shared trace types for the write-back trace buffer.
package tessia_trace_pkg;

  typedef enum logic {
    REG = 1'b0,
    MEM = 1'b1
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e kind;
    logic [63:0] addr;
    logic [63:0] data;
  } trace_entry_t;

  function automatic trace_entry_t make_entry(trace_kind_e kind, logic [63:0] addr,
                                              logic [63:0] data);
    trace_entry_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/writeback_trace_buffer_if.sv
// Trace output stream: valid/ready handshake carrying one trace entry.
interface writeback_trace_buffer_if;
  import tessia_trace_pkg::*;

  logic        trace_valid;
  logic        trace_ready;
  trace_kind_e trace_kind;
  logic [63:0] trace_addr;
  logic [63:0] trace_data;

  modport master (
    output trace_valid,
    output trace_kind,
    output trace_addr,
    output trace_data,
    input  trace_ready
  );

  modport slave (
    input  trace_valid,
    input  trace_kind,
    input  trace_addr,
    input  trace_data,
    output trace_ready
  );

endinterface

// File: rtl/trace_fifo_2w1r.sv
// Trace entry FIFO with two write ports (wr0 first, wr1 second) and one read port.
// wr1_en must only be asserted together with wr0_en; the caller guarantees space.
module trace_fifo_2w1r
  import tessia_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr0_en,
  input  trace_entry_t           wr0_data,
  input  logic                   wr1_en,
  input  trace_entry_t           wr1_data,
  input  logic                   rd_en,
  output trace_entry_t           rd_data,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  trace_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            pop;

  always_comb begin
    pop     = rd_en & (level != '0);
    rd_data = mem[rd_ptr];
  end

  // Storage writes; the second port lands in the slot after the first.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (wr0_en) mem[wr_ptr] <= wr0_data;
      if (wr1_en) mem[wr_ptr + AW'(1)] <= wr1_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr0_en) + AW'(wr1_en);
      rd_ptr <= rd_ptr + AW'(pop);
      level  <= level + LW'(wr0_en) + LW'(wr1_en) - LW'(pop);
    end
  end

endmodule

// File: rtl/writeback_trace_buffer.sv
// Captures core register/memory write-back events into a trace FIFO,
// counting events that had to be dropped for lack of space.
module writeback_trace_buffer
  import tessia_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture_en,
  input  logic                   EnableRegisterWrite,
  input  logic [4:0]             RegisterToWrite,
  input  logic [63:0]            DataToWriteIntoRegister,
  input  logic                   EnableMemoryWrite,
  input  logic [63:0]            AddressToWriteIntoMemory,
  input  logic [63:0]            DataToWriteIntoMemory,
  writeback_trace_buffer_if.master trace,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [DROP_W-1:0]      drop_count,
  input  logic                   overflow_clr
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LAST_LVL = LW'(DEPTH - 1);

  logic         reg_evt;
  logic         mem_evt;
  logic         full;
  logic         one_free;
  logic         accept_reg;
  logic         accept_mem;
  logic         wr0_en;
  logic         wr1_en;
  logic         pop;
  logic [1:0]   n_drop;
  logic [DROP_W:0] drop_sum;
  trace_entry_t reg_entry;
  trace_entry_t mem_entry;
  trace_entry_t wr0_data;
  trace_entry_t head;

  // Admission: free space is judged from the level at the start of the cycle,
  // so a same-cycle pop never makes room. The register event wins the last slot.
  always_comb begin
    reg_evt    = capture_en & EnableRegisterWrite;
    mem_evt    = capture_en & EnableMemoryWrite;
    full       = (level == FULL_LVL);
    one_free   = (level == LAST_LVL);
    accept_reg = reg_evt & ~full;
    accept_mem = mem_evt & ~full & ~(reg_evt & one_free);
    n_drop     = 2'(reg_evt & ~accept_reg) + 2'(mem_evt & ~accept_mem);

    reg_entry  = make_entry(REG, {59'd0, RegisterToWrite}, DataToWriteIntoRegister);
    mem_entry  = make_entry(MEM, AddressToWriteIntoMemory, DataToWriteIntoMemory);

    // Compact accepted events onto the write ports so wr0 is always the older one.
    wr0_en     = accept_reg | accept_mem;
    wr0_data   = accept_reg ? reg_entry : mem_entry;
    wr1_en     = accept_reg & accept_mem;
  end

  trace_fifo_2w1r #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr0_en   (wr0_en),
    .wr0_data (wr0_data),
    .wr1_en   (wr1_en),
    .wr1_data (mem_entry),
    .rd_en    (pop),
    .rd_data  (head),
    .level    (level)
  );

  // Output stream: head entry presented while non-empty, zeros otherwise.
  always_comb begin
    trace.trace_valid = (level != '0);
    pop               = trace.trace_valid & trace.trace_ready;
    if (trace.trace_valid) begin
      trace.trace_kind = head.kind;
      trace.trace_addr = head.addr;
      trace.trace_data = head.data;
    end else begin
      trace.trace_kind = REG;
      trace.trace_addr = '0;
      trace.trace_data = '0;
    end
    drop_sum = {1'b0, drop_count} + (DROP_W + 1)'(n_drop);
  end

  // Sticky overflow flag and saturating drop counter; clear beats a new drop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (overflow_clr) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (n_drop != 2'd0) begin
      overflow   <= 1'b1;
      drop_count <= drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end
  end

endmodule

// File: tb/tb_writeback_trace_buffer.sv
// Bench for writeback_trace_buffer: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_writeback_trace_buffer;
  import tessia_trace_pkg::*;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DROP_W = 16;
  localparam int unsigned DC_MAX = (1 << DROP_W) - 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        capture_en = 1'b0;
  logic        rw = 1'b0;
  logic [4:0]  ri = '0;
  logic [63:0] rd = '0;
  logic        mw = 1'b0;
  logic [63:0] ma = '0;
  logic [63:0] md = '0;
  logic        clr = 1'b0;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  writeback_trace_buffer_if tif ();

  writeback_trace_buffer #(
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .capture_en               (capture_en),
    .EnableRegisterWrite      (rw),
    .RegisterToWrite          (ri),
    .DataToWriteIntoRegister  (rd),
    .EnableMemoryWrite        (mw),
    .AddressToWriteIntoMemory (ma),
    .DataToWriteIntoMemory    (md),
    .trace                    (tif),
    .level                    (level),
    .overflow                 (overflow),
    .drop_count               (drop_count),
    .overflow_clr             (clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending events and plain integer counters.
  typedef struct {
    logic        kind;
    logic [63:0] addr;
    logic [63:0] data;
  } ev_t;

  ev_t         q[$];
  ev_t         acc[$];
  ev_t         ev;
  int          free_slots;
  int unsigned drops;
  int unsigned m_dc = 0;
  logic        m_ovf = 1'b0;
  bit          live = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      q.delete();
      m_dc  = 0;
      m_ovf = 1'b0;
      live  = 1'b1;
    end else begin
      free_slots = int'(DEPTH) - q.size();
      drops      = 0;
      acc.delete();
      if (capture_en && rw) begin
        ev.kind = 1'b0; ev.addr = {59'd0, ri}; ev.data = rd;
        if (free_slots > 0) begin acc.push_back(ev); free_slots--; end
        else drops++;
      end
      if (capture_en && mw) begin
        ev.kind = 1'b1; ev.addr = ma; ev.data = md;
        if (free_slots > 0) begin acc.push_back(ev); free_slots--; end
        else drops++;
      end
      if (q.size() > 0 && tif.trace_ready) void'(q.pop_front());
      foreach (acc[i]) q.push_back(acc[i]);
      if (clr) begin
        m_ovf = 1'b0;
        m_dc  = 0;
      end else if (drops > 0) begin
        m_ovf = 1'b1;
        m_dc  = (m_dc + drops > DC_MAX) ? DC_MAX : m_dc + drops;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (live) begin
      check("valid", 64'(tif.trace_valid), 64'(q.size() != 0));
      check("kind", 64'(tif.trace_kind), (q.size() != 0) ? 64'(q[0].kind) : 64'd0);
      check("addr", tif.trace_addr, (q.size() != 0) ? q[0].addr : 64'd0);
      check("data", tif.trace_data, (q.size() != 0) ? q[0].data : 64'd0);
      check("level", 64'(level), 64'(q.size()));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("drop_count", 64'(drop_count), 64'(m_dc));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_dual(input logic [63:0] tag);
    rw = 1'b1; ri = tag[4:0]; rd = 64'hAA00 + tag;
    mw = 1'b1; ma = 64'h8000 + tag; md = 64'hBB00 + tag;
  endtask

  task automatic idle_strobes();
    rw = 1'b0; mw = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tif.trace_ready = 1'b0;
    step(); step();
    check("rst_level", 64'(level), 64'd0);
    check("rst_valid", 64'(tif.trace_valid), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_dc", 64'(drop_count), 64'd0);

    reset = 1'b1; capture_en = 1'b1;
    step();

    // Single register write R5 = 0x2A.
    rw = 1'b1; ri = 5'd5; rd = 64'h2A;
    step();
    idle_strobes();
    check("r5_valid", 64'(tif.trace_valid), 64'd1);
    check("r5_kind", 64'(tif.trace_kind), 64'd0);
    check("r5_addr", tif.trace_addr, 64'd5);
    check("r5_data", tif.trace_data, 64'h2A);
    tif.trace_ready = 1'b1;
    step();
    tif.trace_ready = 1'b0;
    check("r5_popped", 64'(level), 64'd0);

    // Same-cycle R3 = 7 and MEMORY[0x100] = 9.
    rw = 1'b1; ri = 5'd3; rd = 64'd7;
    mw = 1'b1; ma = 64'h100; md = 64'd9;
    step();
    idle_strobes();
    check("dual_lvl2", 64'(level), 64'd2);
    check("dual_first_kind", 64'(tif.trace_kind), 64'd0);
    check("dual_first_addr", tif.trace_addr, 64'd3);
    tif.trace_ready = 1'b1;
    step();
    check("dual_lvl1", 64'(level), 64'd1);
    check("dual_second_kind", 64'(tif.trace_kind), 64'd1);
    check("dual_second_addr", tif.trace_addr, 64'h100);
    check("dual_second_data", tif.trace_data, 64'd9);
    step();
    check("dual_lvl0", 64'(level), 64'd0);
    tif.trace_ready = 1'b0;

    // Fill to 16 then a dual write: both dropped.
    for (int i = 0; i < 16; i++) begin
      rw = 1'b1; ri = 5'(i); rd = 64'h1000 + 64'(i);
      step();
    end
    set_dual(64'd31);
    step();
    idle_strobes();
    check("full_lvl", 64'(level), 64'd16);
    check("full_ovf", 64'(overflow), 64'd1);
    check("full_dc", 64'(drop_count), 64'd2);
    check("full_head", tif.trace_data, 64'h1000);

    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_dc", 64'(drop_count), 64'd0);

    tif.trace_ready = 1'b1;
    step();
    tif.trace_ready = 1'b0;
    check("pop_lvl15", 64'(level), 64'd15);

    // One free slot: register kept, memory dropped.
    set_dual(64'd7);
    step();
    check("one_free_lvl", 64'(level), 64'd16);
    check("one_free_dc", 64'(drop_count), 64'd1);

    // Full with a same-cycle pop: pop adds no space, both dropped.
    tif.trace_ready = 1'b1;
    set_dual(64'd8);
    step();
    check("pop_full_lvl", 64'(level), 64'd15);
    check("pop_full_dc", 64'(drop_count), 64'd3);

    // Clear wins over a same-cycle drop.
    tif.trace_ready = 1'b0;
    clr = 1'b1;
    set_dual(64'd9);
    step();
    clr = 1'b0;
    check("clr_prio_lvl", 64'(level), 64'd16);
    check("clr_prio_ovf", 64'(overflow), 64'd0);
    check("clr_prio_dc", 64'(drop_count), 64'd0);

    // Capture disabled: strobes ignored, popping continues.
    capture_en = 1'b0;
    tif.trace_ready = 1'b1;
    set_dual(64'd10);
    repeat (3) step();
    check("cap_off_lvl", 64'(level), 64'd13);
    check("cap_off_dc", 64'(drop_count), 64'd0);
    capture_en = 1'b1;
    tif.trace_ready = 1'b0;

    // Saturation of the drop counter.
    idle_strobes();
    rw = 1'b1;
    repeat (3) step();
    set_dual(64'd11);
    repeat (32767) step();
    check("sat_pre", 64'(drop_count), 64'hFFFE);
    mw = 1'b0;
    step();
    check("sat_hit", 64'(drop_count), 64'hFFFF);
    mw = 1'b1;
    step();
    idle_strobes();
    check("sat_hold", 64'(drop_count), 64'hFFFF);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("sat_clr", 64'(drop_count), 64'd0);

    // Reset mid-operation with level 7, alongside push and pop.
    tif.trace_ready = 1'b1;
    repeat (9) step();
    check("pre_rst_lvl", 64'(level), 64'd7);
    set_dual(64'd12);
    reset = 1'b0;
    step();
    check("mid_rst_lvl", 64'(level), 64'd0);
    check("mid_rst_valid", 64'(tif.trace_valid), 64'd0);
    check("mid_rst_addr", tif.trace_addr, 64'd0);
    check("mid_rst_data", tif.trace_data, 64'd0);
    check("mid_rst_wptr", 64'(dut.u_fifo.wr_ptr), 64'd0);
    check("mid_rst_rptr", 64'(dut.u_fifo.rd_ptr), 64'd0);
    reset = 1'b1;
    tif.trace_ready = 1'b0;
    idle_strobes();
    rw = 1'b1; ri = 5'd1; rd = 64'h11;
    step();
    idle_strobes();
    check("post_rst_lvl", 64'(level), 64'd1);
    check("post_rst_addr", tif.trace_addr, 64'd1);
    check("post_rst_data", tif.trace_data, 64'h11);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/writeback_trace_buffer.md
WRITEBACK_TRACE_BUFFER -- requirements
Module: writeback_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entry count; legal values are powers of two, 4 to 256.
REQ-002 SHALL have parameter DROP_W, default 16, meaning dropped-event counter width.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-low reset, sampled on rising clk.
REQ-005 SHALL have port capture_en  input  1  meaning accept core write events when 1.
REQ-006 SHALL have port EnableRegisterWrite  input  1  meaning core register write-back strobe.
REQ-007 SHALL have port RegisterToWrite  input  5  meaning destination register index.
REQ-008 SHALL have port DataToWriteIntoRegister  input  64  meaning register write-back data.
REQ-009 SHALL have port EnableMemoryWrite  input  1  meaning core store strobe.
REQ-010 SHALL have port AddressToWriteIntoMemory  input  64  meaning store address.
REQ-011 SHALL have port DataToWriteIntoMemory  input  64  meaning store data.
REQ-012 SHALL have port trace_valid  output  1  meaning head entry available.
REQ-013 SHALL have port trace_ready  input  1  meaning consumer accepts head entry.
REQ-014 SHALL have port trace_kind  output  1  meaning 0 = register event, 1 = memory event.
REQ-015 SHALL have port trace_addr  output  64  meaning register index zero-extended, or memory address.
REQ-016 SHALL have port trace_data  output  64  meaning written value.
REQ-017 SHALL have port level  output  $clog2(DEPTH)+1  meaning current occupied entries.
REQ-018 SHALL have port overflow  output  1  meaning sticky flag: an event was dropped.
REQ-019 SHALL have port drop_count  output  DROP_W  meaning saturating count of dropped events.
REQ-020 SHALL have port overflow_clr  input  1  meaning clear overflow and drop_count.

Function
REQ-021 SHALL sample the strobe inputs on each rising clk while capture_en=1 and reset=1.
REQ-022 SHALL enqueue at most two events per cycle.
REQ-023 SHALL order same-cycle events as register event first, memory event second.
REQ-024 SHALL make an enqueued event visible at the head no earlier than one cycle after its sampling edge.
REQ-025 SHALL compute free space from level at the start of the cycle; a same-cycle pop does not add space.
REQ-026 SHALL, with one free slot and two events, store the register event and drop the memory event.
REQ-027 SHALL, with zero free slots, drop every offered event.
REQ-028 SHALL, on any drop, set overflow and add the number dropped (1 or 2) to drop_count, saturating at all-ones.
REQ-029 SHALL pop the head on a rising edge where trace_valid=1 and trace_ready=1.
REQ-030 SHALL hold trace_kind/addr/data stable while trace_valid=1 and trace_ready=0.
REQ-031 SHALL drive trace_valid = (level != 0).
REQ-032 SHALL wrap read and write pointers modulo DEPTH.
REQ-033 SHALL update level by pushes minus pop in the same cycle.
REQ-034 SHALL give overflow_clr priority over a same-cycle drop: the result is overflow=0 and drop_count=0.
REQ-035 SHALL ignore the strobes when capture_en=0, without counting drops; popping continues.

Reset
REQ-036 SHALL, when reset=0 at a rising edge, set both pointers and level to 0, and set overflow and drop_count to 0.
REQ-037 SHALL, while held in reset, drive trace_valid=0 and trace_kind/addr/data=0.
REQ-038 SHALL discard all queued entries and any same-cycle push or pop when reset is asserted mid-operation.

Structure
REQ-039 SHALL place the trace_kind_e enum (REG=0, MEM=1) and the trace_entry_t struct (kind, addr[63:0], data[63:0]) in shared package tessia_trace_pkg.
REQ-040 SHALL implement storage in one sub-module, trace_fifo_2w1r (two write ports, one read port, parameter DEPTH).

Verification
REQ-041 SHALL cover: single register write R5=0x2A -> one cycle later trace_valid=1, kind=0, addr=5, data=0x2A.
REQ-042 SHALL cover: same-cycle R3=7 and MEMORY[0x100]=9 -> pops yield the register event, then the memory event; level goes 2, 1, 0.
REQ-043 SHALL cover: DEPTH=16, ready=0, and 16 register writes followed by 1 dual write -> level=16, overflow=1, drop_count=2.
REQ-044 SHALL cover: level=15 plus a dual write -> register event stored, memory event dropped, level=16, drop_count=1.
REQ-045 SHALL cover: drop_count at 0xFFFF plus another drop -> drop_count stays 0xFFFF; overflow_clr then yields 0.
REQ-046 SHALL cover: reset=0 asserted with level=7 -> next cycle level=0, trace_valid=0, pointers 0.
